// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin arbiter sharing one read-only memory port among
// CNT masters. Each master has a cap on its outstanding requests. Responses come
// back in order and are routed to their issuing master through an index FIFO.
module mem_rr_arbiter #(
  parameter int CNT             = 3,
  parameter int QUEUE_DEPTH     = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CNT-1:0]            master_req_valid,
  output logic [CNT-1:0]            master_req_ready,
  input  logic [CNT*ADDR_WIDTH-1:0] master_req_data,
  output logic [CNT-1:0]            master_resp_valid,
  input  logic [CNT-1:0]            master_resp_ready,
  output logic [CNT*DATA_WIDTH-1:0] master_resp_data,
  output logic                      slave_req_valid,
  input  logic                      slave_req_ready,
  output logic [ADDR_WIDTH-1:0]     slave_req_data,
  input  logic                      slave_resp_valid,
  output logic                      slave_resp_ready,
  input  logic [DATA_WIDTH-1:0]     slave_resp_data
);

  localparam int IDX_W = $clog2(CNT);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int FA_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int FC_W  = $clog2(QUEUE_DEPTH + 1);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] search_sel;
  logic [IDX_W-1:0] lock_idx;
  logic [IDX_W-1:0] head;
  logic             lock;
  logic [CNT_W-1:0] cnt [CNT];
  logic [CNT-1:0]   eligible;
  logic             any_eligible;

  logic [IDX_W-1:0] fifo_mem [QUEUE_DEPTH];
  logic [FA_W-1:0]  wr_ptr;
  logic [FA_W-1:0]  rd_ptr;
  logic [FC_W-1:0]  fifo_count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;

  // A master may compete only while it is below its outstanding cap.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < CNT; i++) begin
      eligible[i] = master_req_valid[i] && (cnt[i] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  assign any_eligible = |eligible;

  // Rotating search from ptr with an explicit wrap, so non-power-of-2 CNT works.
  always_comb begin : grant_search
    logic [IDX_W:0]   idx;
    logic [IDX_W-1:0] cand;
    logic             found;
    search_sel = ptr;
    found      = 1'b0;
    idx        = '0;
    cand       = '0;
    for (int off = 0; off < CNT; off++) begin
      idx = {1'b0, ptr} + (IDX_W+1)'(off);
      if (idx >= (IDX_W+1)'(CNT)) begin
        idx = idx - (IDX_W+1)'(CNT);
      end
      cand = idx[IDX_W-1:0];
      if (!found && eligible[cand]) begin
        search_sel = cand;
        found      = 1'b1;
      end
    end
  end

  assign sel        = lock ? lock_idx : search_sel;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FC_W'(QUEUE_DEPTH));
  assign head       = fifo_mem[rd_ptr];

  // Response side: the head entry decides which master sees the response.
  // A full FIFO still accepts a push when a pop happens in the same cycle.
  always_comb begin
    slave_resp_ready  = rst && !fifo_empty && master_resp_ready[head];
    pop               = slave_resp_ready && slave_resp_valid;
    slave_req_valid   = rst && (lock || any_eligible) && (!fifo_full || pop);
    push              = slave_req_valid && slave_req_ready;
    master_req_ready  = '0;
    master_resp_valid = '0;
    for (int i = 0; i < CNT; i++) begin
      master_req_ready[i]  = push && (sel == IDX_W'(i));
      master_resp_valid[i] = rst && slave_resp_valid && !fifo_empty && (head == IDX_W'(i));
    end
  end

  // Forward the granted master's address; response data is broadcast.
  always_comb begin
    slave_req_data = '0;
    for (int i = 0; i < CNT; i++) begin
      if (sel == IDX_W'(i)) begin
        slave_req_data = master_req_data[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
    master_resp_data = {CNT{slave_resp_data}};
  end

  // Rotation pointer and lock: a stalled grant is frozen until it fires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
    end else if (push) begin
      ptr  <= (sel == IDX_W'(CNT - 1)) ? '0 : sel + IDX_W'(1);
      lock <= 1'b0;
    end else if (slave_req_valid && !slave_req_ready) begin
      lock     <= 1'b1;
      lock_idx <= sel;
    end
  end

  // Per-master outstanding counters; a same-cycle issue and return cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CNT; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CNT; i++) begin
        if (master_req_ready[i] && !(master_resp_valid[i] && master_resp_ready[i])) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (!master_req_ready[i] && master_resp_valid[i] && master_resp_ready[i]) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  // Routing FIFO storage; contents need no reset since occupancy is reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= sel;
    end
  end

  // Routing FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == FA_W'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr + FA_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == FA_W'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr + FA_W'(1);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + FC_W'(1);
      end else if (pop && !push) begin
        fifo_count <= fifo_count - FC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: directed vectors for the round-robin memory arbiter with
// CNT=3, QUEUE_DEPTH=4, MAX_OUTSTANDING=2.
module tb_mem_rr_arbiter;

  localparam int CNT = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [CNT-1:0]    master_req_valid;
  logic [CNT-1:0]    master_req_ready;
  logic [CNT*AW-1:0] master_req_data;
  logic [CNT-1:0]    master_resp_valid;
  logic [CNT-1:0]    master_resp_ready;
  logic [CNT*DW-1:0] master_resp_data;
  logic              slave_req_valid;
  logic              slave_req_ready;
  logic [AW-1:0]     slave_req_data;
  logic              slave_resp_valid;
  logic              slave_resp_ready;
  logic [DW-1:0]     slave_resp_data;

  typedef struct {
    logic [2:0] mv;
    logic       sr;
    logic       rv;
    logic [2:0] mr;
    logic       ev;
    logic [2:0] emq;
    int         esel;
    logic       esrr;
    logic [2:0] emrv;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int step_no  = 0;
  vec_t tbl[$];

  mem_rr_arbiter #(
    .CNT(CNT), .QUEUE_DEPTH(4), .MAX_OUTSTANDING(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .master_req_valid(master_req_valid),
    .master_req_ready(master_req_ready),
    .master_req_data(master_req_data),
    .master_resp_valid(master_resp_valid),
    .master_resp_ready(master_resp_ready),
    .master_resp_data(master_resp_data),
    .slave_req_valid(slave_req_valid),
    .slave_req_ready(slave_req_ready),
    .slave_req_data(slave_req_data),
    .slave_resp_valid(slave_resp_valid),
    .slave_resp_ready(slave_resp_ready),
    .slave_resp_data(slave_resp_data)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] addr_of(input int i);
    return 32'h1000_0004 + 32'(i) * 32'h0000_0100;
  endfunction

  function automatic logic [31:0] resp_of(input int s);
    return 32'hD000_0000 + 32'(s);
  endfunction

  function automatic vec_t mk(input logic [2:0] mv, input logic sr, input logic rv,
                              input logic [2:0] mr, input logic ev, input logic [2:0] emq,
                              input int esel, input logic esrr, input logic [2:0] emrv);
    vec_t v;
    v.mv = mv; v.sr = sr; v.rv = rv; v.mr = mr;
    v.ev = ev; v.emq = emq; v.esel = esel; v.esrr = esrr; v.emrv = emrv;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s (step %0d): got %h expected %h", name, step_no, act, exp_v);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    master_req_valid  = v.mv;
    slave_req_ready   = v.sr;
    slave_resp_valid  = v.rv;
    master_resp_ready = v.mr;
    slave_resp_data   = resp_of(step_no);
  endtask

  task automatic check_output(input vec_t v);
    check("slave_req_valid", 32'(slave_req_valid), 32'(v.ev));
    check("master_req_ready", 32'(master_req_ready), 32'(v.emq));
    check("slave_resp_ready", 32'(slave_resp_ready), 32'(v.esrr));
    check("master_resp_valid", 32'(master_resp_valid), 32'(v.emrv));
    if (v.ev) begin
      check("slave_req_data", slave_req_data, addr_of(v.esel));
    end
    for (int i = 0; i < CNT; i++) begin
      if (v.emrv[i]) begin
        check("master_resp_data", master_resp_data[i*DW +: DW], resp_of(step_no));
      end
    end
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_slave_req_valid"}, 32'(slave_req_valid), 32'd0);
    check({tag, "_master_req_ready"}, 32'(master_req_ready), 32'd0);
    check({tag, "_slave_resp_ready"}, 32'(slave_resp_ready), 32'd0);
    check({tag, "_master_resp_valid"}, 32'(master_resp_valid), 32'd0);
  endtask

  task automatic step(input vec_t v);
    apply_stimulus(v);
    #2;
    check_output(v);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  // Reset with busy inputs so the output gating is exercised.
  task automatic do_reset();
    rst               = 1'b0;
    master_req_valid  = 3'b111;
    slave_req_ready   = 1'b1;
    slave_resp_valid  = 1'b1;
    master_resp_ready = 3'b111;
    slave_resp_data   = '0;
    #2;
    check_all_low("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < CNT; i++) begin
      master_req_data[i*AW +: AW] = addr_of(i);
    end

    // Rotation with responses two cycles after each request, then drain.
    tbl.push_back(mk(3'b111, 1, 0, 3'b111, 1, 3'b001, 0, 0, 3'b000));
    tbl.push_back(mk(3'b111, 1, 0, 3'b111, 1, 3'b010, 1, 1, 3'b000));
    tbl.push_back(mk(3'b111, 1, 1, 3'b111, 1, 3'b100, 2, 1, 3'b001));
    tbl.push_back(mk(3'b111, 1, 1, 3'b111, 1, 3'b001, 0, 1, 3'b010));
    tbl.push_back(mk(3'b111, 1, 1, 3'b111, 1, 3'b010, 1, 1, 3'b100));
    tbl.push_back(mk(3'b111, 1, 1, 3'b111, 1, 3'b100, 2, 1, 3'b001));
    tbl.push_back(mk(3'b000, 1, 1, 3'b111, 0, 3'b000, 0, 1, 3'b010));
    tbl.push_back(mk(3'b000, 1, 1, 3'b111, 0, 3'b000, 0, 1, 3'b100));
    tbl.push_back(mk(3'b000, 1, 1, 3'b111, 0, 3'b000, 0, 0, 3'b000));
    // Per-master cap: master 0 alone, two fire, stall, one response, third fires.
    tbl.push_back(mk(3'b001, 1, 0, 3'b111, 1, 3'b001, 0, 0, 3'b000));
    tbl.push_back(mk(3'b001, 1, 0, 3'b111, 1, 3'b001, 0, 1, 3'b000));
    tbl.push_back(mk(3'b001, 1, 0, 3'b111, 0, 3'b000, 0, 1, 3'b000));
    tbl.push_back(mk(3'b001, 1, 0, 3'b111, 0, 3'b000, 0, 1, 3'b000));
    tbl.push_back(mk(3'b001, 1, 1, 3'b111, 0, 3'b000, 0, 1, 3'b001));
    tbl.push_back(mk(3'b001, 1, 0, 3'b111, 1, 3'b001, 0, 1, 3'b000));
    tbl.push_back(mk(3'b000, 1, 1, 3'b111, 0, 3'b000, 0, 1, 3'b001));
    tbl.push_back(mk(3'b000, 1, 1, 3'b111, 0, 3'b000, 0, 1, 3'b001));
    tbl.push_back(mk(3'b000, 1, 1, 3'b111, 0, 3'b000, 0, 0, 3'b000));

    do_reset();
    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k]);
    end

    // Lock: master 1 stalled three cycles while master 0 asks; then 1, then 2, then 0.
    do_reset();
    step(mk(3'b010, 0, 0, 3'b111, 1, 3'b000, 1, 0, 3'b000));
    step(mk(3'b011, 0, 0, 3'b111, 1, 3'b000, 1, 0, 3'b000));
    step(mk(3'b011, 0, 0, 3'b111, 1, 3'b000, 1, 0, 3'b000));
    step(mk(3'b011, 1, 0, 3'b111, 1, 3'b010, 1, 0, 3'b000));
    step(mk(3'b101, 1, 0, 3'b111, 1, 3'b100, 2, 1, 3'b000));
    step(mk(3'b001, 1, 0, 3'b111, 1, 3'b001, 0, 1, 3'b000));

    // FIFO full: four fire (0,1,2,0), stall, push+pop while full, drain in order.
    do_reset();
    step(mk(3'b111, 1, 0, 3'b111, 1, 3'b001, 0, 0, 3'b000));
    step(mk(3'b111, 1, 0, 3'b111, 1, 3'b010, 1, 1, 3'b000));
    step(mk(3'b111, 1, 0, 3'b111, 1, 3'b100, 2, 1, 3'b000));
    step(mk(3'b111, 1, 0, 3'b111, 1, 3'b001, 0, 1, 3'b000));
    step(mk(3'b111, 1, 0, 3'b111, 0, 3'b000, 0, 1, 3'b000));
    step(mk(3'b111, 1, 1, 3'b111, 1, 3'b010, 1, 1, 3'b001));
    step(mk(3'b111, 1, 0, 3'b111, 0, 3'b000, 0, 1, 3'b000));
    step(mk(3'b000, 1, 1, 3'b111, 0, 3'b000, 0, 1, 3'b010));
    step(mk(3'b000, 1, 1, 3'b111, 0, 3'b000, 0, 1, 3'b100));
    step(mk(3'b000, 1, 1, 3'b111, 0, 3'b000, 0, 1, 3'b001));
    step(mk(3'b000, 1, 1, 3'b111, 0, 3'b000, 0, 1, 3'b010));
    step(mk(3'b000, 1, 1, 3'b111, 0, 3'b000, 0, 0, 3'b000));

    // Response backpressure on master 2, then a single transfer frees its cap.
    do_reset();
    step(mk(3'b100, 1, 0, 3'b111, 1, 3'b100, 2, 0, 3'b000));
    step(mk(3'b100, 1, 0, 3'b111, 1, 3'b100, 2, 1, 3'b000));
    step(mk(3'b100, 1, 1, 3'b011, 0, 3'b000, 0, 0, 3'b100));
    step(mk(3'b100, 1, 1, 3'b011, 0, 3'b000, 0, 0, 3'b100));
    step(mk(3'b100, 1, 1, 3'b111, 0, 3'b000, 0, 1, 3'b100));
    step(mk(3'b100, 1, 0, 3'b111, 1, 3'b100, 2, 1, 3'b000));

    // Asynchronous reset mid-burst with three entries in flight.
    do_reset();
    step(mk(3'b111, 1, 0, 3'b111, 1, 3'b001, 0, 0, 3'b000));
    step(mk(3'b111, 1, 0, 3'b111, 1, 3'b010, 1, 1, 3'b000));
    step(mk(3'b111, 1, 0, 3'b111, 1, 3'b100, 2, 1, 3'b000));
    begin
      vec_t v;
      v = mk(3'b111, 1, 1, 3'b111, 1, 3'b001, 0, 1, 3'b001);
      apply_stimulus(v);
      #2;
      check_output(v);
      rst = 1'b0;
      #1;
      check_all_low("async_reset");
      step_no++;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
    end
    step(mk(3'b100, 1, 1, 3'b111, 1, 3'b100, 2, 0, 3'b000));
    step(mk(3'b000, 1, 1, 3'b111, 0, 3'b000, 0, 1, 3'b100));
    step(mk(3'b000, 1, 1, 3'b111, 0, 3'b000, 0, 0, 3'b000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
# mem_rr_arbiter

Round-robin memory arbiter that shares one read-only memory slave port among CNT masters. Each master has a configurable cap on its outstanding requests. Responses return in order and are routed to the master that issued the request, using an internal index FIFO. It sits between the core's fetch/load/prefetch requesters and the cache or bus port, and replaces fixed-priority arbitration where fairness is needed.

## Interface
- CNT, 3: number of masters; must be at least 2.
- QUEUE_DEPTH, 4: depth of the in-flight routing FIFO; bounds total outstanding requests.
- MAX_OUTSTANDING, 2: per-master cap on issued but unanswered requests; 1..QUEUE_DEPTH.
- ADDR_WIDTH, 32: request payload width (address).
- DATA_WIDTH, 32: response payload width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- master_req[CNT]  decoupled.in  ADDR_WIDTH  per-master request (valid/ready/data).
- master_resp[CNT]  decoupled.out  DATA_WIDTH  per-master response.
- slave_req  decoupled.out  ADDR_WIDTH  shared request to the memory.
- slave_resp  decoupled.in  DATA_WIDTH  in-order responses from the memory.

## Operation
- A master i is **eligible** when master_req[i].valid is 1 and cnt[i] < MAX_OUTSTANDING.
- **Grant search:**
  - When not locked, sel is the first eligible index scanning ptr, ptr+1, … modulo CNT.
  - ptr is a $clog2(CNT)-bit register; wrap is explicit, so index CNT-1 is followed by 0, including when CNT is not a power of 2.
- **Lock:**
  - If slave_req.valid=1 and slave_req.ready=0 at a clock edge, set lock=1 and lock_idx=sel.
  - While locked, sel=lock_idx regardless of other masters or ptr, so slave_req.data stays stable until the transfer fires.
  - Clear lock on slave_req fire.
- **Request path:**
  - slave_req.valid = (locked or any eligible) and FIFO not full.
  - slave_req.data = master_req[sel].data.
  - master_req[i].ready = slave_req fire and sel==i. This is 1 for at most one i.
- **On slave_req fire:**
  - Push sel into the routing FIFO.
  - Set ptr to sel+1 mod CNT.
  - Increment cnt[sel].
- **Response path:**
  - Let head = FIFO front.
  - master_resp[i].valid = slave_resp.valid and FIFO non-empty and head==i.
  - master_resp[i].data = slave_resp.data for all i.
  - slave_resp.ready = FIFO non-empty and master_resp[head].ready.
  - On fire, pop the FIFO and decrement cnt[head].
- **Counters:** cnt[i] is $clog2(MAX_OUTSTANDING+1) bits wide. If the same master sees request fire and response fire in one cycle, cnt is unchanged. cnt never exceeds MAX_OUTSTANDING and never underflows; a response arriving with an empty FIFO is not accepted.
- **FIFO:** non-fallthrough. An entry pushed in cycle t is visible at head from t+1.
- **Simultaneous events:** a FIFO push and pop in the same cycle are both allowed, including when the FIFO is full.
- **Full:** a FIFO full at the edge blocks new requests (slave_req.valid=0) unless a pop occurs in the same cycle; in that case the push is allowed. slave_req.valid may therefore depend on slave_resp.ready.

## Timing
- **Reset (rst=0):** takes effect immediately, asynchronously.
  - ptr=0, lock=0, all cnt=0, FIFO empty.
  - slave_req.valid=0, all master_req.ready=0, all master_resp.valid=0, slave_resp.ready=0.
  - Outputs are also forced low while rst=0.
- **Reset mid-operation:** in-flight entries are discarded. The memory slave must be reset together with the arbiter.
- **Request latency:** 0 cycles. Master valid to slave_req.valid is combinational in the same cycle when a grant is available.
- **Response latency:** 0 cycles. slave_resp.valid to master_resp.valid is combinational.
- **Minimum round trip:** a response can be accepted no earlier than 1 cycle after its request fires.
- **Grant rotation:** takes effect on the cycle after a fire.
- **Lock hold:** a locked grant is held for every cycle until slave_req.ready=1.
- **Throughput:** one request and one response per cycle are sustainable.

## Test plan
- **Rotation:** CNT=3, MAX_OUTSTANDING=2, QUEUE_DEPTH=4. Masters 0,1,2 all valid, slave ready every cycle, responses returned 2 cycles after each request → grant order 0,1,2,0,1,2; each response is routed to its issuing master.
- **Lock:** master 1 granted with slave_req.ready=0 for 3 cycles while master 0 raises valid → slave_req.data holds master 1's address for all 3 cycles; master 1 fires first; master 2 is next if valid, otherwise master 0.
- **Per-master cap:** only master 0 valid, no responses returned → exactly 2 requests fire, then slave_req.valid=0. One response → a third request fires 1 cycle later.
- **FIFO full:** 3 masters, no responses, MAX_OUTSTANDING=2 → 4 requests fire (order 0,1,2,0), then no more. A response and a request in the same cycle → both fire and the FIFO stays at 4.
- **Response backpressure:** head=2 with master_resp[2].ready=0 → slave_resp.ready=0 and master_resp[0/1].valid=0. Raise ready → single transfer, cnt[2] decrements.
- **Async reset:** assert rst=0 mid-burst with 3 entries in flight → all outputs 0 within the same cycle. After release, master 2 alone requests → granted first from ptr=0, with no stale responses routed.
